// File: rtl/tx_bridge_pkg.sv
// Shared constants and state encodings for the cpu-tx to UART bridge.
package tx_bridge_pkg;

  localparam logic [6:0] TX_OPEN  = 7'h00;
  localparam logic [6:0] TX_CLOSE = 7'h7F;
  localparam logic [7:0] TX_LF    = 8'h0A;

  typedef enum logic {
    DET_IDLE     = 1'b0,
    DET_IN_FRAME = 1'b1
  } det_state_t;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/tx_char_fifo.sv
// Character FIFO with an extra pointer bit to tell full from empty.
// A push while full is only accepted when a pop happens in the same cycle.
module tx_char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign wr_en_s = push && (!full || pop);
  assign rd_en_s = pop && !empty;
  assign rdata   = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; both wrap naturally through the extra MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tx_uart_bridge.sv
// Frames cpu tx characters (0x00 open, 0x7F close) into a FIFO and drains it as 8N1 UART.
// Optional TX_BRIDGE_EOL_LF_EN: a close marker also enqueues a line feed.
module tx_uart_bridge
  import tx_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] tx_in,
  output logic       uart_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       overflow
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1'b1);

  det_state_t    det_state_r;
  ser_state_t    ser_state_r;
  logic          frame_done_r;
  logic          overflow_r;
  logic          uart_txd_r;
  logic          busy_r;
  logic [TW-1:0] timer_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;

  logic          push_s;
  logic [7:0]    push_data_s;
  logic          close_s;
  logic          pop_s;
  logic          line_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [7:0]    fifo_rdata_s;

  tx_char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (push_data_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Marker decode: the push must land in the same cycle the character is seen.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = {1'b0, tx_in};
    close_s     = 1'b0;
    case (det_state_r)
      DET_IDLE: begin
        push_s = 1'b0;
      end
      DET_IN_FRAME: begin
        if (tx_in == TX_CLOSE) begin
          close_s = 1'b1;
`ifdef TX_BRIDGE_EOL_LF_EN
          push_s      = 1'b1;
          push_data_s = TX_LF;
`endif
        end else if (tx_in == TX_OPEN) begin
          push_s = 1'b0;
        end else begin
          push_s = 1'b1;
        end
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Frame detector state, end-of-frame pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      det_state_r  <= DET_IDLE;
      frame_done_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      frame_done_r <= close_s;
      if (push_s && fifo_full_s && !pop_s) overflow_r <= 1'b1;
      case (det_state_r)
        DET_IDLE:     det_state_r <= (tx_in == TX_OPEN) ? DET_IN_FRAME : DET_IDLE;
        DET_IN_FRAME: det_state_r <= close_s ? DET_IDLE : DET_IN_FRAME;
        default:      det_state_r <= DET_IDLE;
      endcase
    end
  end

  // Pop when idle or at the last stop-bit cycle, so characters chain with no gap.
  always_comb begin
    pop_s = 1'b0;
    if (!fifo_empty_s && ((ser_state_r == SER_IDLE) ||
        ((ser_state_r == SER_STOP) && (timer_r == TIMER_LAST)))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Line level implied by the current serializer state.
  always_comb begin
    line_s = 1'b1;
    case (ser_state_r)
      SER_IDLE:  line_s = 1'b1;
      SER_START: line_s = 1'b0;
      SER_DATA:  line_s = shift_r[bit_idx_r];
      SER_STOP:  line_s = 1'b1;
      default:   line_s = 1'b1;
    endcase
  end

  // Serializer FSM; the line and busy are registered one cycle behind the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ser_state_r <= SER_IDLE;
      timer_r     <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      uart_txd_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      uart_txd_r <= line_s;
      busy_r     <= !fifo_empty_s || (ser_state_r != SER_IDLE);
      case (ser_state_r)
        SER_IDLE: begin
          timer_r <= '0;
          if (pop_s) begin
            shift_r     <= fifo_rdata_s;
            ser_state_r <= SER_START;
          end
        end
        SER_START: begin
          if (timer_r == TIMER_LAST) begin
            timer_r     <= '0;
            bit_idx_r   <= 3'd0;
            ser_state_r <= SER_DATA;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        SER_DATA: begin
          if (timer_r == TIMER_LAST) begin
            timer_r <= '0;
            if (bit_idx_r == 3'd7) ser_state_r <= SER_STOP;
            else                   bit_idx_r   <= bit_idx_r + 3'd1;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        SER_STOP: begin
          if (timer_r == TIMER_LAST) begin
            timer_r <= '0;
            if (pop_s) begin
              shift_r     <= fifo_rdata_s;
              ser_state_r <= SER_START;
            end else begin
              ser_state_r <= SER_IDLE;
            end
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        default: begin
          ser_state_r <= SER_IDLE;
          timer_r     <= '0;
        end
      endcase
    end
  end

  assign uart_txd   = uart_txd_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;

endmodule
